sram_sp_responder: RTL and testbench



---
 rtl/sram_sp_responder.sv | 104 ++++++++++
 tb/tb_sram_sp_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_responder.sv
// Synthesizable single-port SRAM responder for the AHB SRAM controller's memory-side pins.
// Configurable read latency, read-valid strobe, saturating access counters and a sticky range-error flag.
module sram_sp_responder #(
  parameter int AW           = 13,
  parameter int DW           = 8,
  parameter int DEPTH        = 8192,
  parameter int READ_LATENCY = 1
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  output logic          q_valid,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt,
  output logic          addr_err,
  input  logic          clr_stat
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sram_sp_responder: READ_LATENCY must be in 1..4");
  end
  if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
    $error("sram_sp_responder: DEPTH must be in 1..2**AW");
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DW-1:0] mem [DEPTH];

  logic          wr_fire;
  logic          rd_fire;
  logic          in_range;
  logic [IW-1:0] idx;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] rd_data_p [READ_LATENCY];
  logic          vld_p     [READ_LATENCY];

  // An unknown WEN with the chip selected falls into the read branch.
  always_comb begin
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    if (CEN == 1'b0) begin
      if (WEN == 1'b0) wr_fire = 1'b1;
      else             rd_fire = 1'b1;
    end
  end

  assign in_range = {1'b0, A} < DEPTH_L;
  assign idx      = A[IW-1:0];
  assign rd_data  = in_range ? mem[idx] : '0;

  always_ff @(posedge hclk) begin
    if (wr_fire && in_range) mem[idx] <= D;
  end

  // Stage 0 captures at the sampling edge; the last stage is the data register behind Q.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        vld_p[s]     <= 1'b0;
        rd_data_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= rd_fire;
      if (rd_fire) rd_data_p[0] <= rd_data;
      for (int s = 1; s < READ_LATENCY; s++) begin
        vld_p[s] <= vld_p[s-1];
        if (vld_p[s-1]) rd_data_p[s] <= rd_data_p[s-1];
      end
    end
  end

  assign Q       = OEN ? '0 : rd_data_p[READ_LATENCY-1];
  assign q_valid = vld_p[READ_LATENCY-1];

  // Clear wins over a same-cycle increment or error.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      addr_err <= 1'b0;
    end else if (clr_stat) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      addr_err <= 1'b0;
    end else begin
      if (wr_fire) wr_cnt <= sat_inc(wr_cnt);
      if (rd_fire) rd_cnt <= sat_inc(rd_cnt);
      if ((wr_fire || rd_fire) && !in_range) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_sp_responder.sv
// Bench for sram_sp_responder: three instances (latency 1, 2, 3) share one stimulus stream,
// a vector table for the basic protocol plus sequences for multi-cycle corners, and a read scoreboard.
module tb_sram_sp_responder;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 4096;
  localparam int RLV [3] = '{1, 2, 3};

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          CEN, WEN, OEN, clr_stat;
  logic [AW-1:0] A;
  logic [DW-1:0] D;

  logic [DW-1:0] q_o  [3];
  logic          qv_o [3];
  logic [15:0]   wc_o [3];
  logic [15:0]   rc_o [3];
  logic          ae_o [3];

  always #5 hclk = ~hclk;

  sram_sp_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_rl1 (
    .hclk(hclk), .hresetn(hresetn), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D),
    .Q(q_o[0]), .q_valid(qv_o[0]), .wr_cnt(wc_o[0]), .rd_cnt(rc_o[0]),
    .addr_err(ae_o[0]), .clr_stat(clr_stat));

  sram_sp_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .READ_LATENCY(2)) u_rl2 (
    .hclk(hclk), .hresetn(hresetn), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D),
    .Q(q_o[1]), .q_valid(qv_o[1]), .wr_cnt(wc_o[1]), .rd_cnt(rc_o[1]),
    .addr_err(ae_o[1]), .clr_stat(clr_stat));

  sram_sp_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .READ_LATENCY(3)) u_rl3 (
    .hclk(hclk), .hresetn(hresetn), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D),
    .Q(q_o[2]), .q_valid(qv_o[2]), .wr_cnt(wc_o[2]), .rd_cnt(rc_o[2]),
    .addr_err(ae_o[2]), .clr_stat(clr_stat));

  typedef struct {
    logic [DW-1:0] data;
    int            iss;
  } exp_t;

  typedef struct {
    logic          cen, wen, oen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic          qv;
    logic [15:0]   wc, rc;
  } vec_t;

  exp_t          sb [$];
  int            head [3];
  int            cyc;
  int            n_cmp;
  int            n_err;
  logic [DW-1:0] mdl [DEPTH];
  vec_t          tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each instance consumes the shared read stream at its own latency.
  task automatic sb_monitor();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (qv_o[i]) begin
        if (head[i] >= sb.size()) begin
          chk($sformatf("rl%0d_unexpected_qvalid", RLV[i]), 32'(qv_o[i]), 32'd0);
        end else begin
          e = sb[head[i]];
          head[i]++;
          chk($sformatf("rl%0d_qvalid_cycle", RLV[i]), 32'(cyc), 32'(e.iss + RLV[i]));
          chk($sformatf("rl%0d_read_data", RLV[i]), 32'(q_o[i]), OEN ? 32'd0 : 32'(e.data));
        end
      end else if (head[i] < sb.size() && sb[head[i]].iss + RLV[i] <= cyc) begin
        chk($sformatf("rl%0d_missing_qvalid", RLV[i]), 32'(qv_o[i]), 32'd1);
        head[i]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    cyc++;
    @(negedge hclk);
    sb_monitor();
  endtask

  task automatic drive(input logic cen, input logic wen, input logic oen,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic clr);
    exp_t e;
    CEN = cen; WEN = wen; OEN = oen; A = a; D = d; clr_stat = clr;
    if (!cen) begin
      if (!wen) begin
        if (int'(a) < DEPTH) mdl[a[11:0]] = d;
      end else begin
        e.data = (int'(a) < DEPTH) ? mdl[a[11:0]] : '0;
        e.iss  = cyc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0]    pat;
    logic [DW-1:0] qs [3];
    int            nq;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 13'h001, 8'h12, 8'h00, 1'b0, 16'd1, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 13'h004, 8'h34, 8'h00, 1'b0, 16'd2, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 8'h12, 1'b1, 16'd2, 16'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 13'h004, 8'h00, 8'h34, 1'b1, 16'd2, 16'd2};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 13'h000, 8'h00, 8'h34, 1'b0, 16'd2, 16'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 13'h001, 8'h55, 8'h34, 1'b0, 16'd3, 16'd2};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 8'h55, 1'b1, 16'd3, 16'd3};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 13'h001, 8'h12, 8'h55, 1'b0, 16'd4, 16'd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 13'h001, 8'h00, 8'h00, 1'b1, 16'd4, 16'd4};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 13'h000, 8'h00, 8'h12, 1'b0, 16'd4, 16'd4};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 13'hFFF, 8'h7E, 8'h12, 1'b0, 16'd5, 16'd4};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 13'hFFF, 8'h00, 8'h7E, 1'b1, 16'd5, 16'd5};

    n_cmp = 0; n_err = 0; cyc = 0;
    for (int i = 0; i < 3; i++) head[i] = 0;
    hresetn = 1'b0;
    idle();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rl%0d_reset_q", RLV[i]), 32'(q_o[i]), 32'd0);
      chk($sformatf("rl%0d_reset_qvalid", RLV[i]), 32'(qv_o[i]), 32'd0);
      chk($sformatf("rl%0d_reset_wr_cnt", RLV[i]), 32'(wc_o[i]), 32'd0);
      chk($sformatf("rl%0d_reset_rd_cnt", RLV[i]), 32'(rc_o[i]), 32'd0);
      chk($sformatf("rl%0d_reset_addr_err", RLV[i]), 32'(ae_o[i]), 32'd0);
    end
    hresetn = 1'b1;
    tick();

    // Basic protocol on the latency-1 instance, one row per clock.
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].cen, tbl[k].wen, tbl[k].oen, tbl[k].a, tbl[k].d, 1'b0);
      tick();
      chk($sformatf("vec%0d_q", k), 32'(q_o[0]), 32'(tbl[k].q));
      chk($sformatf("vec%0d_qvalid", k), 32'(qv_o[0]), 32'(tbl[k].qv));
      chk($sformatf("vec%0d_wr_cnt", k), 32'(wc_o[0]), 32'(tbl[k].wc));
      chk($sformatf("vec%0d_rd_cnt", k), 32'(rc_o[0]), 32'(tbl[k].rc));
    end
    idle();
    repeat (4) tick();

    // Back-to-back reads seen through the latency-3 instance.
    drive(1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 13'h004, 8'h00, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 1'b0); tick();
    idle();
    pat = '0; nq = 0;
    for (int j = 0; j < 3; j++) qs[j] = '0;
    for (int j = 0; j < 6; j++) begin
      pat[j] = qv_o[2];
      if (qv_o[2] && nq < 3) begin
        qs[nq] = q_o[2];
        nq++;
      end
      if (j < 5) tick();
    end
    chk("rl3_b2b_qvalid_pattern", 32'(pat), 32'h07);
    chk("rl3_b2b_q0", 32'(qs[0]), 32'h12);
    chk("rl3_b2b_q1", 32'(qs[1]), 32'h34);
    chk("rl3_b2b_q2", 32'(qs[2]), 32'h12);

    // Out-of-range write/read, then statistics clear.
    drive(1'b0, 1'b0, 1'b0, 13'h000, 8'h5A, 1'b0); tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("rl%0d_addr_err_in_range", RLV[i]), 32'(ae_o[i]), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 13'h1000, 8'hAA, 1'b0); tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("rl%0d_addr_err_set", RLV[i]), 32'(ae_o[i]), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 13'h1000, 8'h00, 1'b0); tick();
    chk("rl1_oor_read_q", 32'(q_o[0]), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 13'h000, 8'h00, 1'b0); tick();
    chk("rl1_mem0_unchanged", 32'(q_o[0]), 32'h5A);
    idle();
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rl%0d_addr_err_sticky", RLV[i]), 32'(ae_o[i]), 32'd1);
      chk($sformatf("rl%0d_wr_cnt_total", RLV[i]), 32'(wc_o[i]), 32'd7);
      chk($sformatf("rl%0d_rd_cnt_total", RLV[i]), 32'(rc_o[i]), 32'd10);
    end
    drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b1); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rl%0d_clr_addr_err", RLV[i]), 32'(ae_o[i]), 32'd0);
      chk($sformatf("rl%0d_clr_wr_cnt", RLV[i]), 32'(wc_o[i]), 32'd0);
      chk($sformatf("rl%0d_clr_rd_cnt", RLV[i]), 32'(rc_o[i]), 32'd0);
    end

    // Reset while a latency-2 read is still in flight.
    drive(1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 1'b0); tick();
    hresetn = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) head[i] = sb.size();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("rl%0d_midreset_q", RLV[i]), 32'(q_o[i]), 32'd0);
    chk("rl2_midreset_qvalid", 32'(qv_o[1]), 32'd0);
    tick();
    tick();
    chk("rl2_in_reset_qvalid", 32'(qv_o[1]), 32'd0);
    hresetn = 1'b1;
    repeat (3) tick();
    chk("rl2_after_reset_q", 32'(q_o[1]), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 1'b0); tick();
    idle(); tick();
    chk("rl2_post_reset_qvalid", 32'(qv_o[1]), 32'd1);
    chk("rl2_post_reset_q", 32'(q_o[1]), 32'h12);
    repeat (3) tick();

    // Read counter saturation and clear priority.
    drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b1); tick();
    for (int n = 0; n < 65534; n++) begin
      drive(1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 1'b0);
      tick();
    end
    idle(); tick();
    chk("rl1_rd_cnt_fffe", 32'(rc_o[0]), 32'hFFFE);
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 1'b0);
      tick();
    end
    idle(); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rl%0d_rd_cnt_sat", RLV[i]), 32'(rc_o[i]), 32'hFFFF);
      chk($sformatf("rl%0d_wr_cnt_idle", RLV[i]), 32'(wc_o[i]), 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 13'h001, 8'h00, 1'b1); tick();
    idle();
    for (int i = 0; i < 3; i++)
      chk($sformatf("rl%0d_clr_beats_inc", RLV[i]), 32'(rc_o[i]), 32'd0);
    repeat (5) tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("rl%0d_scoreboard_drained", RLV[i]), 32'(head[i]), 32'(sb.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
